// File: rtl/ps2_kbd_controller.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_controller
// Purpose  : PS/2 keyboard host receiver: frame decode, E0/F0 prefix tracking,
//            present-key register and make/break event FIFO.
//            Optional frame watchdog compiled in with `define KBD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_controller #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] pres_key,
    output logic        evt_valid,
    output logic [15:0] evt_data,
    input  logic        evt_ready,
    output logic        frame_err,
    output logic        ovf
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Pin synchronisers; reset to the idle-high line level so no false edge follows reset
    logic [2:0] r_clk_s;
    logic [1:0] r_data_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s  <= 3'b111;
            r_data_s <= 2'b11;
        end else begin
            r_clk_s  <= {r_clk_s[1:0], ps2_clk};
            r_data_s <= {r_data_s[0], ps2_data};
        end
    end

    logic w_fall;
    logic w_bit;
    assign w_fall = r_clk_s[2] & ~r_clk_s[1];
    assign w_bit  = r_data_s[1];

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_bitcnt;
    logic [7:0] r_shift;
    logic       r_par;
    logic       w_timeout;
    logic       w_stop_ok;
    logic       w_stop_bad;
    logic       w_par_ok;

    assign w_par_ok = ^{r_shift, r_par};

`ifdef KBD_TIMEOUT_EN
    localparam int c_TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_TMR_W-1:0] r_timer;

    // An edge arriving on the terminal count still wins over the abort
    assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                       (r_timer == c_TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if ((r_state == ST_IDLE) || w_fall || w_timeout) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stop_ok   = 1'b0;
        w_stop_bad  = 1'b0;
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_bit) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    if (w_bit && w_par_ok) begin
                        w_stop_ok = 1'b1;
                    end else begin
                        w_stop_bad = 1'b1;
                    end
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_par    <= 1'b0;
        end else if (w_fall && !w_timeout) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_bit) begin
                        r_bitcnt <= 3'd0;
                        r_shift  <= 8'h00;
                    end
                end
                ST_DATA: begin
                    r_shift  <= {w_bit, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
                ST_PARITY: r_par <= w_bit;
                default: ;
            endcase
        end
    end

    // Byte acceptance and prefix tracking
    logic        r_ext_pend;
    logic        r_brk_pend;
    logic        w_is_e0;
    logic        w_is_f0;
    logic        w_event;
    logic [15:0] w_evt_word;

    assign w_is_e0    = (r_shift == 8'hE0);
    assign w_is_f0    = (r_shift == 8'hF0);
    assign w_event    = w_stop_ok && !w_is_e0 && !w_is_f0;
    assign w_evt_word = {r_brk_pend, 6'b0, r_ext_pend, r_shift};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_stop_bad || w_timeout) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_stop_ok) begin
            if (w_is_e0) begin
                r_ext_pend <= 1'b1;
            end else if (w_is_f0) begin
                r_brk_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
        end
    end

    logic [15:0] r_pres_key;
    logic        r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pres_key  <= 16'h0000;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad || w_timeout;
            if (w_event) begin
                if (!r_brk_pend) begin
                    r_pres_key <= {7'b0, r_ext_pend, r_shift};
                end else if (r_pres_key[8:0] == {r_ext_pend, r_shift}) begin
                    r_pres_key <= 16'h0000;
                end
            end
        end
    end

    // Show-ahead event FIFO; a pop frees room for a same-cycle push when full
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;
    logic            r_ovf;
    logic            w_evt_valid;
    logic            w_full;
    logic            w_pop;
    logic            w_push;

    assign w_evt_valid = (r_count != '0);
    assign w_full      = (r_count == (c_AW+1)'(FIFO_DEPTH));
    assign w_pop       = w_evt_valid && evt_ready;
    assign w_push      = w_event && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_evt_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= w_event && w_full && !w_pop;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pres_key  = r_pres_key;
    assign evt_valid = w_evt_valid;
    assign evt_data  = w_evt_valid ? r_mem[r_rptr] : 16'h0000;
    assign frame_err = r_frame_err;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
